// File: rtl/muldiv_sched.sv
// HI/LO multiply/divide sequencer: latches a result on Start, holds Busy for a fixed
// latency, then commits to HI/LO; also serves MTHI/MTLO writes and mfhi/mflo reads.
module muldiv_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [3:0]  MULDIVMode,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HILOSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MULDIVOut
);

    localparam logic [3:0] ModeNothing = 4'd0;
    localparam logic [3:0] ModeMult    = 4'd1;
    localparam logic [3:0] ModeMultu   = 4'd2;
    localparam logic [3:0] ModeDiv     = 4'd3;
    localparam logic [3:0] ModeDivu    = 4'd4;
    localparam logic [3:0] ModeMthi    = 4'd5;
    localparam logic [3:0] ModeMtlo    = 4'd6;
    localparam logic [3:0] ModeFdiv    = 4'd7;

    localparam int unsigned MaxCycles = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d, lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic              pend_we_q, pend_we_d;

    logic              is_mul, is_div;
    logic [63:0]       prod_s, prod_u;
    logic [31:0]       divisor, a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
    logic [31:0]       res_hi, res_lo;

    assign is_mul = (MULDIVMode == ModeMult) || (MULDIVMode == ModeMultu);
    assign is_div = (MULDIVMode == ModeDiv) || (MULDIVMode == ModeDivu);

    // Arithmetic for the pending result; divisor forced nonzero to keep quotient defined.
    always_comb begin
        prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
        prod_u  = {32'd0, A} * {32'd0, B};
        divisor = (B == 32'd0) ? 32'd1 : B;
        a_mag   = A[31] ? (32'd0 - A) : A;
        b_mag   = divisor[31] ? (32'd0 - divisor) : divisor;
        q_mag   = a_mag / b_mag;
        r_mag   = a_mag % b_mag;
        // Sign-magnitude division makes 0x80000000 / -1 wrap naturally to 0x80000000.
        q_s     = (A[31] ^ divisor[31]) ? (32'd0 - q_mag) : q_mag;
        r_s     = A[31] ? (32'd0 - r_mag) : r_mag;
        q_u     = A / divisor;
        r_u     = A % divisor;
        res_hi  = 32'd0;
        res_lo  = 32'd0;
        case (MULDIVMode)
            ModeMult:  {res_hi, res_lo} = prod_s;
            ModeMultu: {res_hi, res_lo} = prod_u;
            ModeDiv:   begin res_hi = r_s; res_lo = q_s; end
            ModeDivu:  begin res_hi = r_u; res_lo = q_u; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        unique case (state_q)
            StIdle: begin
                if (Start && (is_mul || is_div)) begin
                    pend_hi_d = res_hi;
                    pend_lo_d = res_lo;
                    pend_we_d = !(is_div && (B == 32'd0));
                    cnt_d     = is_mul ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
                    state_d   = StRun;
                end else if (MULDIVMode == ModeMthi) begin
                    hi_d = A;
                end else if (MULDIVMode == ModeMtlo) begin
                    lo_d = A;
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    if (pend_we_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        Busy      = (state_q == StRun);
        HI        = hi_q;
        LO        = lo_q;
        MULDIVOut = HILOSel ? hi_q : lo_q;
    end

    // FDIV and NOTHING intentionally fall through with no state change.
    logic unused_modes;
    assign unused_modes = (MULDIVMode == ModeFdiv) || (MULDIVMode == ModeNothing);

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: latency, arithmetic, MTHI/MTLO, reset abort and
// protocol-error immunity, each checked against hand-computed values.
module tb_muldiv_sched;

    localparam logic [3:0] MNothing = 4'd0;
    localparam logic [3:0] MMult    = 4'd1;
    localparam logic [3:0] MMultu   = 4'd2;
    localparam logic [3:0] MDiv     = 4'd3;
    localparam logic [3:0] MDivu    = 4'd4;
    localparam logic [3:0] MMthi    = 4'd5;
    localparam logic [3:0] MMtlo    = 4'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start = 1'b0;
    logic [3:0]  MULDIVMode = MNothing;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        HILOSel = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO, MULDIVOut;

    int checks = 0;
    int errors = 0;

    muldiv_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MULDIVMode(MULDIVMode),
        .A(A), .B(B), .HILOSel(HILOSel), .Busy(Busy), .HI(HI), .LO(LO),
        .MULDIVOut(MULDIVOut)
    );

    always #5 clk = ~clk;

    // Advance to the next cycle; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic s, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] b);
        Start = s; MULDIVMode = m; A = a; B = b;
        step();
        Start = 1'b0; MULDIVMode = MNothing;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        Start = 1'b1; MULDIVMode = MMult; A = 32'd9; B = 32'd9;
        step(); step();
        Start = 1'b0; MULDIVMode = MNothing;
        reset = 1'b1;
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", Busy); end
        checks++;
        if (HI !== 32'd0 || LO !== 32'd0) begin
            errors++; $display("FAIL reset_hilo got %h/%h want 0/0", HI, LO);
        end
        step();
        checks++;
        if (Busy !== 1'b0) begin errors++; $display("FAIL reset_start_busy got %0b want 0", Busy); end
    endtask

    task automatic test_multu;
        issue(1'b1, MMultu, 32'hFFFF_FFFF, 32'd2);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (Busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
                errors++;
                $display("FAIL multu_busy cyc%0d got busy=%0b hi=%h lo=%h want 1/0/0", i, Busy, HI, LO);
            end
            step();
        end
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h1 || LO !== 32'hFFFF_FFFE) begin
            errors++;
            $display("FAIL multu_commit got busy=%0b hi=%h lo=%h want 0/00000001/fffffffe", Busy, HI, LO);
        end
    endtask

    task automatic test_mult;
        issue(1'b1, MMult, -32'sd3, 32'sd7);
        for (int i = 1; i <= 5; i++) begin
            checks++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL mult_busy cyc%0d got %0b want 1", i, Busy); end
            step();
        end
        checks++;
        if (Busy !== 1'b0 || HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_commit got busy=%0b hi=%h lo=%h want 0/ffffffff/ffffffeb", Busy, HI, LO);
        end
        HILOSel = 1'b1; #1;
        checks++;
        if (MULDIVOut !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL mfhi got %h want ffffffff", MULDIVOut);
        end
        HILOSel = 1'b0; #1;
        checks++;
        if (MULDIVOut !== 32'hFFFF_FFEB) begin
            errors++; $display("FAIL mflo got %h want ffffffeb", MULDIVOut);
        end
    endtask

    task automatic test_div;
        issue(1'b1, MDiv, -32'sd7, 32'sd2);
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL div_busy cyc%0d got %0b want 1", i, Busy); end
            step();
        end
        checks++;
        if (Busy !== 1'b0 || LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_commit got busy=%0b hi=%h lo=%h want 0/ffffffff/fffffffd", Busy, HI, LO);
        end
        issue(1'b1, MDiv, 32'h8000_0000, 32'hFFFF_FFFF);
        repeat (10) step();
        checks++;
        if (Busy !== 1'b0 || LO !== 32'h8000_0000 || HI !== 32'h0) begin
            errors++;
            $display("FAIL div_ovf got busy=%0b hi=%h lo=%h want 0/00000000/80000000", Busy, HI, LO);
        end
    endtask

    task automatic test_divzero;
        issue(1'b0, MMthi, 32'h1234, 32'd0);
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h1234) begin
            errors++; $display("FAIL mthi got busy=%0b hi=%h want 0/00001234", Busy, HI);
        end
        issue(1'b0, MMtlo, 32'h1234, 32'd0);
        checks++;
        if (Busy !== 1'b0 || LO !== 32'h1234) begin
            errors++; $display("FAIL mtlo got busy=%0b lo=%h want 0/00001234", Busy, LO);
        end
        issue(1'b1, MDivu, 32'd55, 32'd0);
        for (int i = 1; i <= 10; i++) begin
            checks++;
            if (Busy !== 1'b1) begin errors++; $display("FAIL div0_busy cyc%0d got %0b want 1", i, Busy); end
            step();
        end
        checks++;
        if (Busy !== 1'b0 || HI !== 32'h1234 || LO !== 32'h1234) begin
            errors++;
            $display("FAIL div0_keep got busy=%0b hi=%h lo=%h want 0/00001234/00001234", Busy, HI, LO);
        end
    endtask

    task automatic test_reset_inflight;
        issue(1'b1, MMult, 32'd5, 32'd6);
        step(); step();
        // Cycle 3: counter holds 3
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
            errors++;
            $display("FAIL abort got busy=%0b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
                errors++;
                $display("FAIL late_commit cyc%0d got busy=%0b hi=%h lo=%h want 0/0/0", i, Busy, HI, LO);
            end
        end
    endtask

    task automatic test_back_to_back;
        issue(1'b1, MMultu, 32'd3, 32'd4);
        for (int i = 1; i <= 5; i++) begin
            if (i == 2) begin Start = 1'b1; MULDIVMode = MDivu; A = 32'd100; B = 32'd7; end
            if (i == 3) begin Start = 1'b0; MULDIVMode = MMtlo; A = 32'hDEAD; end
            if (i == 4) MULDIVMode = MNothing;
            checks++;
            if (Busy !== 1'b1 || LO !== 32'd0) begin
                errors++;
                $display("FAIL ignore_run cyc%0d got busy=%0b lo=%h want 1/0", i, Busy, LO);
            end
            step();
        end
        checks++;
        if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd12) begin
            errors++;
            $display("FAIL ignore_commit got busy=%0b hi=%h lo=%h want 0/0/0000000c", Busy, HI, LO);
        end
        step();
        checks++;
        if (Busy !== 1'b0 || LO !== 32'd12) begin
            errors++; $display("FAIL ignore_after got busy=%0b lo=%h want 0/0000000c", Busy, LO);
        end
    endtask

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_divzero();
        test_reset_inflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
